// File: rtl/sumador_arbiter.sv
// rtl/sumador_arbiter.sv - two-requester round-robin front end to one registered adder
module sumador_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_carry,
    output logic             busy,
    output logic [7:0]       op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last_id;
    logic             sel_id;
    logic             any_req;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic             cap_id;
    logic [WIDTH:0]   sum_full;

    assign any_req  = req0 | req1;
    assign sum_full = {1'b0, cap_a} + {1'b0, cap_b};
    assign busy     = (state != IDLE);

    // Round-robin pick: a lone request wins outright, a tie goes to whoever was not served last
    always_comb begin
        sel_id = req1;
        if (req0 && req1) begin
            sel_id = ~last_id;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one pass through EXEC, then park in RESP until the consumer takes it
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant outputs: only offered from IDLE, and suppressed while reset is held
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && (state == IDLE) && any_req) begin
            gnt0 = ~sel_id;
            gnt1 = sel_id;
        end
    end

    // Datapath: operand capture on grant, registered add, response hold and completion count
    always_ff @(posedge clk) begin
        if (rst) begin
            last_id   <= 1'b1;
            cap_a     <= '0;
            cap_b     <= '0;
            cap_id    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= 1'b0;
            op_count  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cap_a   <= sel_id ? a1 : a0;
                        cap_b   <= sel_id ? b1 : b0;
                        cap_id  <= sel_id;
                        last_id <= sel_id;
                    end
                end
                EXEC: begin
                    rsp_sum   <= sum_full[WIDTH-1:0];
                    rsp_carry <= sum_full[WIDTH];
                    rsp_id    <= cap_id;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sumador_arbiter.md
# sumador_arbiter

Shares one registered WIDTH-bit adder between two requesters on the Tiny Tapeout user tile. Each requester presents an operand pair with a request. A round-robin arbiter grants one requester at a time. A three-state FSM sequences capture, add and response delivery. The block returns the sum, carry-out and requester ID over a valid/ready handshake, and keeps a wrapping count of completed operations for debug output on uo_out.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 request.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- req1  input  1  requester 1 request.
- a1  input  WIDTH  requester 1 operand A.
- b1  input  WIDTH  requester 1 operand B.
- gnt0  output  1  one-cycle grant to requester 0; operands 0 are sampled on the closing edge.
- gnt1  output  1  one-cycle grant to requester 1; operands 1 are sampled on the closing edge.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  requester that owns the response.
- rsp_sum  output  WIDTH  (a + b) mod 2^WIDTH.
- rsp_carry  output  1  carry-out of the add.
- busy  output  1  high whenever state is not IDLE.
- op_count  output  8  completed responses, mod 256.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no request is present, stay in IDLE.
  - Otherwise select a requester. With one request, select that requester. With both, select the requester that is not last_id.
  - Assert gnt of the selected requester for this cycle. gnt is combinational from the state, req0/req1 and last_id.
  - On the edge, capture that requester's operands and ID into internal registers, set last_id to the selected ID, and go to EXEC.
- EXEC:
  - Compute the WIDTH+1-bit sum of the captured operands.
  - Register bits [WIDTH-1:0] into rsp_sum and bit WIDTH into rsp_carry. Copy the captured ID to rsp_id.
  - Set rsp_valid to 1 and go to RESP.
- RESP:
  - Hold rsp_valid, rsp_sum, rsp_carry and rsp_id stable until rsp_ready is 1.
  - On the edge with rsp_ready=1: clear rsp_valid, increment op_count (wraps 255→0), go to IDLE.
- No grant is issued outside IDLE. Requests raised during EXEC or RESP wait.
- Requester rules:
  - Hold req and operands stable until gnt is seen.
  - req may be deasserted or reused from the cycle after gnt.
  - A requester that deasserts req before gnt is never granted.
- rsp_sum, rsp_carry and rsp_id keep their last values after the handshake, until the next EXEC.
- busy = (state != IDLE).

## Timing
- Reset, with rst=1 sampled on an edge:
  - state=IDLE, last_id=1 so req0 wins the first tie.
  - rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, op_count=0.
  - gnt0 and gnt1 are forced to 0 while rst=1.
- Reset mid-operation, in EXEC or RESP: the operation is aborted and no response is produced. op_count is not incremented.
- Latency:
  - Grant at cycle t in IDLE.
  - EXEC at t+1.
  - rsp_valid=1 from t+2.
- Throughput: at best one operation every 3 cycles, when rsp_ready is held at 1.
- rsp_ready while rsp_valid=0 is ignored.
- Response accepted in cycle t: IDLE at t+1, so the next grant can come no earlier than t+1.
- Fairness: under continuous requests from both sides, grants strictly alternate 0,1,0,1…
- Arithmetic: the sum is unsigned. Carry is the only overflow indication. There is no saturation.

## Test plan
- Reset then single op:
  - Stimulus: rst for 2 cycles, then req0=1, a0=8'h25, b0=8'h13, rsp_ready=1.
  - Required: gnt0 pulses one cycle. rsp_valid 2 cycles later with rsp_sum=8'h38, rsp_carry=0, rsp_id=0. op_count=1.
- Carry:
  - Stimulus: req1, a1=8'hFF, b1=8'h02.
  - Required: rsp_sum=8'h01, rsp_carry=1, rsp_id=1.
- Tie and alternation:
  - Stimulus: from reset, req0=req1=1 held for 4 operations, rsp_ready=1.
  - Required: grant order 0,1,0,1. No grant during busy=1.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles after rsp_valid, with req0 pending.
  - Required: rsp_sum, rsp_carry and rsp_id stable. No gnt until 1 cycle after the rsp_ready=1 handshake.
- Reset mid-operation:
  - Stimulus: assert rst during EXEC.
  - Required: the next cycle shows rsp_valid=0, busy=0, op_count=0, and no response appears.
- op_count wrap:
  - Stimulus: 256 back-to-back operations.
  - Required: op_count returns to 0.
